// File: rtl/regfile_writeback.sv
// regfile_writeback: register-file writeback stage with scoreboard.
// Merges the load (LSU) and ALU result streams into one registered
// register-file write port. The LSU always wins arbitration. An ALU result
// that loses is parked in a one-entry hold register, and the hold register
// drains on the next cycle without a load. A pending-write mask drives the
// decode stall (hazard).
// Optional feature macro: WB_BYPASS_EN. It adds forwarding of the
// output-stage result to the decode operands and removes that term from
// hazard.
module regfile_writeback #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            write,
    output logic [4:0]      c_address,
    output logic [XLEN-1:0] c_in,
    input  logic [4:0]      a_address,
    input  logic [4:0]      b_address,
    output logic            hazard,
`ifdef WB_BYPASS_EN
    output logic            fwd_a_hit,
    output logic            fwd_b_hit,
    output logic [XLEN-1:0] fwd_a_data,
    output logic [XLEN-1:0] fwd_b_data,
`endif
    output logic [31:0]     pending
);

    logic            hold_valid_r;
    logic [4:0]      hold_rd_r;
    logic [XLEN-1:0] hold_data_r;
    logic            write_r;
    logic [4:0]      c_address_r;
    logic [XLEN-1:0] c_in_r;
    logic [31:0]     pending_r;

    logic            alu_xfer_s;
    logic            sel_valid_s;
    logic [4:0]      sel_rd_s;
    logic [XLEN-1:0] sel_data_s;
    logic            hold_load_s;
    logic            hold_drain_s;
    logic            load_s;
    logic [31:0]     pending_nxt_s;
    logic            match_a_s;
    logic            match_b_s;
    logic            pend_a_s;
    logic            pend_b_s;

    assign alu_ready  = reset & ~hold_valid_r;
    assign alu_xfer_s = alu_valid & alu_ready;
    // A selected result aimed at x0 is dropped.
    assign load_s     = sel_valid_s & (sel_rd_s != 5'd0);

    assign write     = write_r;
    assign c_address = c_address_r;
    assign c_in      = c_in_r;
    assign pending   = pending_r;

    // Source arbitration: LSU first, then the hold entry, then this cycle's ALU transfer.
    always_comb begin
        sel_valid_s  = 1'b0;
        sel_rd_s     = 5'd0;
        sel_data_s   = {XLEN{1'b0}};
        hold_load_s  = 1'b0;
        hold_drain_s = 1'b0;
        if (lsu_valid) begin
            sel_valid_s = 1'b1;
            sel_rd_s    = lsu_rd;
            sel_data_s  = lsu_data;
            hold_load_s = alu_xfer_s;
        end else if (hold_valid_r) begin
            sel_valid_s  = 1'b1;
            sel_rd_s     = hold_rd_r;
            sel_data_s   = hold_data_r;
            hold_drain_s = 1'b1;
        end else if (alu_xfer_s) begin
            sel_valid_s = 1'b1;
            sel_rd_s    = alu_rd;
            sel_data_s  = alu_data;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // Next scoreboard mask: clear on writeback, then set on issue so set wins.
    always_comb begin
        pending_nxt_s = pending_r;
        if (load_s) begin
            pending_nxt_s[sel_rd_s] = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            pending_nxt_s[issue_rd] = 1'b1;
        end else begin
            pending_nxt_s[0] = 1'b0;
        end
        pending_nxt_s[0] = 1'b0;
    end

    // Hold register: park a losing ALU result, release it when the LSU is idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_valid_r <= 1'b0;
            hold_rd_r    <= 5'd0;
            hold_data_r  <= {XLEN{1'b0}};
        end else if (hold_load_s) begin
            hold_valid_r <= 1'b1;
            hold_rd_r    <= alu_rd;
            hold_data_r  <= alu_data;
        end else if (hold_drain_s) begin
            hold_valid_r <= 1'b0;
        end
    end

    // Output stage: one register-file write per cycle; address/data held when idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_r     <= 1'b0;
            c_address_r <= 5'd0;
            c_in_r      <= {XLEN{1'b0}};
        end else begin
            write_r <= load_s;
            if (load_s) begin
                c_address_r <= sel_rd_s;
                c_in_r      <= sel_data_s;
            end
        end
    end

    // Scoreboard register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_r <= 32'd0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    assign match_a_s = write_r & (c_address_r == a_address);
    assign match_b_s = write_r & (c_address_r == b_address);
    assign pend_a_s  = (a_address != 5'd0) & pending_r[a_address];
    assign pend_b_s  = (b_address != 5'd0) & pending_r[b_address];

`ifdef WB_BYPASS_EN
    // Output-stage results are forwarded, so only outstanding writes stall decode.
    always_comb begin
        hazard     = reset & (pend_a_s | pend_b_s);
        fwd_a_hit  = (a_address != 5'd0) & match_a_s;
        fwd_b_hit  = (b_address != 5'd0) & match_b_s;
        fwd_a_data = c_in_r;
        fwd_b_data = c_in_r;
    end
`else
    // Without forwarding, the result in the output stage also stalls decode.
    always_comb begin
        hazard = reset & (pend_a_s | pend_b_s
                          | ((a_address != 5'd0) & match_a_s)
                          | ((b_address != 5'd0) & match_b_s));
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed testbench for regfile_writeback with a write scoreboard.
module tb_regfile_writeback;

    localparam int XLEN = 32;

    logic            clock;
    logic            reset;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            lsu_valid;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            write;
    logic [4:0]      c_address;
    logic [XLEN-1:0] c_in;
    logic [4:0]      a_address;
    logic [4:0]      b_address;
    logic            hazard;
    logic [31:0]     pending;
`ifdef WB_BYPASS_EN
    logic            fwd_a_hit;
    logic            fwd_b_hit;
    logic [XLEN-1:0] fwd_a_data;
    logic [XLEN-1:0] fwd_b_data;
`endif

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    regfile_writeback #(.XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .write(write), .c_address(c_address), .c_in(c_in),
        .a_address(a_address), .b_address(b_address),
        .hazard(hazard),
`ifdef WB_BYPASS_EN
        .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
        .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
`endif
        .pending(pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [XLEN-1:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        q.push_back(e);
    endtask

    // Pop and compare whenever the DUT issues a register-file write.
    task automatic observe();
        wr_t e;
        if (write === 1'b1) begin
            if (q.size() == 0) begin
                chk("wr_spurious", 64'(write), 64'd0);
            end else begin
                e = q.pop_front();
                chk("sb_addr", 64'(c_address), 64'(e.rd));
                chk("sb_data", 64'(c_in), 64'(e.data));
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        observe();
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = 5'd0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle_inputs();
        a_address = 5'd5;
        b_address = 5'd0;
        #2;
        // Reset state
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_caddr", 64'(c_address), 64'd0);
        chk("rst_cin", 64'(c_in), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_ready", 64'(alu_ready), 64'd0);
        chk("rst_hazard", 64'(hazard), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("ready_after_rst", 64'(alu_ready), 64'd1);
        a_address = 5'd0;

        // Issue x5, then ALU result for x5
        tick();
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        chk("pend5_set", 64'(pending), 64'h20);
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
        push(5'd5, 32'h11);
        #1;
        chk("pend5_before_load", 64'(pending[5]), 64'd1);
        chk("ready_idle", 64'(alu_ready), 64'd1);
        tick();
        idle_inputs();
        chk("wr_x5", 64'(write), 64'd1);
        chk("pend5_clr", 64'(pending), 64'd0);

        // LSU and ALU collide: LSU first, ALU parked then drained
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'hAA;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hBB;
        push(5'd3, 32'hAA);
        push(5'd4, 32'hBB);
        tick();
        idle_inputs();
        #1;
        chk("wr_x3", 64'(write), 64'd1);
        chk("ready_hold_full", 64'(alu_ready), 64'd0);
        tick();
        chk("wr_x4", 64'(write), 64'd1);
        chk("ready_drained", 64'(alu_ready), 64'd1);
        tick();
        chk("idle_write", 64'(write), 64'd0);
        chk("idle_caddr_held", 64'(c_address), 64'd4);
        chk("idle_cin_held", 64'(c_in), 64'hBB);

        // ALU result to x0 is dropped
        issue_valid = 1'b1; issue_rd = 5'd2;
        tick();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
        tick();
        idle_inputs();
        chk("x0_write", 64'(write), 64'd0);
        chk("x0_pending", 64'(pending), 64'h4);

        // Issue x7 on the edge its result loads: set wins
        issue_valid = 1'b1; issue_rd = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        push(5'd7, 32'h77);
        tick();
        idle_inputs();
        chk("wr_x7", 64'(write), 64'd1);
        chk("pend7_set_wins", 64'(pending), 64'h84);

        // Output stage writing x9 vs decode operand
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        push(5'd9, 32'h99);
        tick();
        idle_inputs();
        a_address = 5'd9;
        #1;
`ifdef WB_BYPASS_EN
        chk("fwd_hazard", 64'(hazard), 64'd0);
        chk("fwd_a_hit", 64'(fwd_a_hit), 64'd1);
        chk("fwd_a_data", 64'(fwd_a_data), 64'h99);
`else
        chk("match_hazard", 64'(hazard), 64'd1);
`endif
        a_address = 5'd0; b_address = 5'd7;
        #1;
        chk("pend_hazard_b", 64'(hazard), 64'd1);
        b_address = 5'd3;
        #1;
        chk("no_hazard", 64'(hazard), 64'd0);
        b_address = 5'd0;

        // Retire x2 and x7 via loads
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
        push(5'd2, 32'h22);
        tick();
        lsu_rd = 5'd7; lsu_data = 32'h07;
        push(5'd7, 32'h07);
        tick();
        idle_inputs();
        chk("pend_clear_all", 64'(pending), 64'd0);

        // Hold full, pending 0x120, reset mid-cycle
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        issue_rd = 5'd8;
        tick();
        idle_inputs();
        lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h01;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        push(5'd1, 32'h01);
        tick();
        idle_inputs();
        a_address = 5'd5;
        #1;
        chk("pre_rst_pending", 64'(pending), 64'h120);
        chk("pre_rst_ready", 64'(alu_ready), 64'd0);
        chk("pre_rst_hazard", 64'(hazard), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_write", 64'(write), 64'd0);
        chk("mid_rst_pending", 64'(pending), 64'd0);
        chk("mid_rst_ready", 64'(alu_ready), 64'd0);
        chk("mid_rst_hazard", 64'(hazard), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("post_rst_ready", 64'(alu_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_nowrite", 64'(write), 64'd0);
        end
        chk("sb_drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter XLEN, default 32, is the data width of all result and register-write data buses.
REQ-002 Port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 Ports issue_valid/issue_rd, input, 1/5 bits: an instruction with destination issue_rd was issued this cycle.
REQ-005 Ports alu_valid/alu_rd/alu_data, input, 1/5/XLEN bits, and alu_ready, output, 1 bit: ALU result, valid/ready handshake.
REQ-006 Ports lsu_valid/lsu_rd/lsu_data, input, 1/5/XLEN bits: load result; no ready; always accepted.
REQ-007 Ports write/c_address/c_in, output, 1/5/XLEN bits: registered write port driving the register file.
REQ-008 Ports a_address/b_address, input, 5 bits each: source operands of the instruction in decode.
REQ-009 Port hazard, output, 1 bit: decode must stall.
REQ-010 Port pending, output, 32 bits: scoreboard mask; bit n set = write to xn outstanding.

Function
REQ-011 Internal one-entry ALU hold register; alu_ready = reset deasserted AND hold empty; ALU transfer when alu_valid && alu_ready.
REQ-012 Per-cycle source priority for the output stage: lsu_valid first, then hold entry, then the ALU transfer of this cycle.
REQ-013 An ALU transfer not selected this cycle (lsu_valid high) is loaded into hold; hold drains when no lsu_valid.
REQ-014 Latency: selected result appears on write/c_address/c_in on the next rising edge; the stage holds one result per cycle.
REQ-015 Selected result with rd = 0 is dropped: write = 0 next cycle; pending unaffected.
REQ-016 No result selected: write = 0 next cycle; c_address/c_in hold their previous values.
REQ-017 On an edge where issue_valid and issue_rd != 0, pending[issue_rd] sets.
REQ-018 On an edge loading the output stage with rd != 0, pending[rd] clears; same rd set and cleared on the same edge: set wins.
REQ-019 pending[0] is constant 0.
REQ-020 hazard combinational: for operand X in {a,b}, X_address != 0 and (pending[X_address] or output-stage match); match = write && c_address == X_address.
REQ-021 Sustained lsu_valid starves the ALU indefinitely; no fairness is provided.

Reset
REQ-022 While reset = 0, asynchronously: write = 0, c_address = 0, c_in = 0, hold empty, pending = 0, alu_ready = 0, hazard = 0.
REQ-023 Reset mid-operation discards the hold entry and all pending bits; no write is issued for discarded results.
REQ-024 First edge after reset deassertion behaves as a normal cycle; alu_ready = 1 immediately after deassertion.

Configuration
REQ-025 Macro WB_BYPASS_EN adds output ports fwd_a_hit/fwd_b_hit, 1 bit, and fwd_a_data/fwd_b_data, XLEN bits.
REQ-026 With WB_BYPASS_EN: fwd_X_hit = output-stage match for operand X per REQ-020; fwd_X_data = c_in; match term removed from hazard.
REQ-027 Without WB_BYPASS_EN: forward ports absent; hazard includes the output-stage match term.

Verification
REQ-028 Issue rd=5; ALU rd=5 data 0x11 next cycle -> pending[5] 1 until the load edge; write=1, c_address=5, c_in=0x11 one cycle after transfer.
REQ-029 lsu rd=3 0xAA and ALU rd=4 0xBB same cycle -> cycle+1 write x3=0xAA, alu_ready=0; cycle+2 write x4=0xBB; alu_ready=1 again.
REQ-030 ALU rd=0 data 0xFF -> write stays 0; pending unchanged.
REQ-031 Issue rd=7 on the same edge an ALU rd=7 result loads -> pending[7] remains 1 after the edge.
REQ-032 Output stage writing x9, a_address=9 -> hazard=1 without macro; with WB_BYPASS_EN hazard=0, fwd_a_hit=1, fwd_a_data=c_in.
REQ-033 Hold full, pending=0x0000_0120; reset pulled low mid-cycle -> write, pending and hold cleared immediately; no later write of the held result.
